// File: rtl/fec_pkg.sv
// Shared FEC/UART definitions used by the UART TX arbiter slice.
package fec_pkg;

  localparam int unsigned UART_MDW   = 8;
  localparam int unsigned UART_FAW   = 4;
  localparam int unsigned ARB_HOLD_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_pick.sv
// Combinational winner selection for the UART TX arbiter: one-hot result,
// zero when nobody requests.
module uart_tx_arb_pick (
  input  logic [1:0] req,
  input  logic       prio_mode,
  input  logic       last_served,
  output logic [1:0] pick
);

  // Single requester wins outright; a tie goes to requester 0 under fixed
  // priority, otherwise to whichever requester was not served last.
  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (prio_mode || last_served) ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the single UART TX FIFO write port between two message-oriented
// requesters, with FIFO backpressure, optional drain between messages and a
// hold watchdog.
module uart_tx_arbiter
  import fec_pkg::*;
#(
  parameter int MDW    = UART_MDW,
  parameter int FAW    = UART_FAW,
  parameter int HOLD_W = ARB_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [MDW-1:0]    wdata0,
  input  logic [MDW-1:0]    wdata1,
  input  logic [1:0]        last,
  output logic [1:0]        grant,
  output logic [1:0]        wr_ready,
  output logic              fifo_wr,
  output logic [MDW-1:0]    fifo_wdata,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [FAW-1:0]    tx_level,
  input  logic              prio_mode,
  input  logic              drain_en,
  input  logic [HOLD_W-1:0] hold_max,
  output logic [1:0]        drop_err,
  output logic              timeout_flag,
  output logic              arb_busy
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  arb_state_t        state;
  arb_state_t        state_next;
  logic              owner;
  logic              last_served;
  logic [HOLD_W-1:0] hold_cnt;

  logic [1:0]        pick;
  logic              space_ok;
  logic              acc;
  logic              expire;
  logic              release_evt;
  logic              owner_next;
  logic              last_served_next;
  logic [1:0]        grant_next;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              arm_next;

  uart_tx_arb_pick u_pick (
    .req         (req),
    .prio_mode   (prio_mode),
    .last_served (last_served),
    .pick        (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a watchdog release always returns straight to idle.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (|req) state_next = ARB_GRANT;
      ARB_GRANT: begin
        if (expire)           state_next = ARB_IDLE;
        else if (release_evt) state_next = drain_en ? ARB_DRAIN : ARB_IDLE;
      end
      ARB_DRAIN: if (tx_empty && !fifo_wr) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // Handshake, release and watchdog decode plus next values of the
  // registered outputs.
  // timeout_flag is registered one cycle ahead of expiry (armed when the
  // counter is about to reach hold_max-1) so that it is high in the very
  // cycle the forced release is taken.
  always_comb begin
    space_ok    = !tx_full && !(fifo_wr && (tx_level == '1));
    wr_ready    = grant & {2{space_ok}};
    acc         = |(wr & wr_ready);
    expire      = timeout_flag && !acc;
    release_evt = (state == ARB_GRANT) &&
                  ((acc && last[owner]) || !req[owner] || expire);
    arb_busy    = (state != ARB_IDLE);

    owner_next       = owner;
    last_served_next = release_evt ? owner : last_served;
    grant_next       = grant;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_next = pick;
          owner_next = pick[1];
        end
      end
      ARB_GRANT: if (release_evt) grant_next = '0;
      default:   grant_next = '0;
    endcase

    hold_cnt_next = '0;
    if (state == ARB_GRANT && !acc)
      hold_cnt_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_ONE;

    arm_next = (state_next == ARB_GRANT) && (hold_max != '0) &&
               (hold_cnt_next == hold_max - HOLD_ONE);
  end

  // Grant, datapath and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      owner        <= 1'b0;
      last_served  <= 1'b1;
      hold_cnt     <= '0;
      timeout_flag <= 1'b0;
      drop_err     <= '0;
      fifo_wr      <= 1'b0;
      fifo_wdata   <= '0;
    end else begin
      grant        <= grant_next;
      owner        <= owner_next;
      last_served  <= last_served_next;
      hold_cnt     <= hold_cnt_next;
      timeout_flag <= arm_next;
      drop_err     <= wr & ~wr_ready;
      fifo_wr      <= acc;
      if (acc) fifo_wdata <= owner ? wdata1 : wdata0;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO between two message-oriented requesters: the FEC control FSM downlink path (requester 0) and the uplink FEC engine (requester 1). It grants exclusive access for a whole message and registers the granted requester's writes into the UART TX FIFO, with backpressure from the FIFO level. Optionally it waits for the FIFO to drain before re-arbitrating, and a watchdog releases a requester that stalls while holding the grant. It sits between the requesters and the UART write port, replacing direct wr/req wiring at the top level.

## Interface
- MDW, 8: data width; equals UART_MDW.
- FAW, 4: UART FIFO address width; FIFO depth is 2**FAW.
- HOLD_W, 16: watchdog counter width.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester request; held high for the whole message
- wr  in  2  per-requester write strobe
- wdata0  in  MDW  requester 0 data
- wdata1  in  MDW  requester 1 data
- last  in  2  marks a write as the final byte of the message
- grant  out  2  one-hot (or zero) grant, registered
- wr_ready  out  2  write accepted this cycle if wr is high; combinational
- fifo_wr  out  1  registered write strobe to the UART TX FIFO
- fifo_wdata  out  MDW  registered write data to the UART TX FIFO
- tx_full  in  1  UART TX FIFO full
- tx_empty  in  1  UART TX FIFO empty
- tx_level  in  FAW  UART TX FIFO fill level
- prio_mode  in  1  0 = round-robin, 1 = fixed priority to requester 0
- drain_en  in  1  1 = wait for the FIFO to empty after each message
- hold_max  in  HOLD_W  watchdog limit in idle-grant cycles; 0 disables the watchdog
- drop_err  out  2  one-cycle pulse when a write is refused
- timeout_flag  out  1  one-cycle pulse when the watchdog forces a release
- arb_busy  out  1  high in any state other than ARB_IDLE

## Operation
- States are ARB_IDLE, ARB_GRANT and ARB_DRAIN.
- **ARB_IDLE:**
  - If req is non-zero, pick the owner and go to ARB_GRANT; grant[owner] is high from the next cycle.
  - In round-robin mode, when both requesters are asserted, the requester not recorded in last_served wins.
  - last_served resets to 1, so requester 0 wins the first tie.
  - In fixed-priority mode, requester 0 always wins a tie.
- **ARB_GRANT:**
  - wr_ready[g] = grant[g] & ~tx_full & ~(fifo_wr & tx_level == 2**FAW-1). The last term covers the write already in flight.
  - wr_ready of the non-owner is always 0.
  - An accepted write (wr & wr_ready) loads fifo_wr and fifo_wdata on the next edge.
  - A write that is not accepted is dropped and pulses drop_err[i] for one cycle. This includes a write from a non-owner.
- **Release** happens on an accepted write with last set, or when req[owner] goes low.
  - On release, last_served takes the owner and the state goes to ARB_DRAIN if drain_en is set, otherwise ARB_IDLE.
- **ARB_DRAIN:** return to ARB_IDLE when tx_empty & ~fifo_wr.
- **Watchdog:**
  - hold_cnt clears on entry to ARB_GRANT and on every accepted write; otherwise it increments in ARB_GRANT and saturates.
  - When hold_max != 0 and hold_cnt == hold_max-1 with no accepted write, the arbiter pulses timeout_flag, performs the release, and goes to ARB_IDLE regardless of drain_en.
- **Simultaneous events:**
  - Accepted last write together with req falling: the write is forwarded, then a single release.
  - A last write that is refused does not release; the requester retries.
  - Watchdog expiry and an accepted write in the same cycle: the write wins and the counter clears.
- The grant never moves directly between requesters; at least one cycle in ARB_IDLE separates grants.
- **Reset:**
  - Asserting reset at any time, including mid-message, forces ARB_IDLE and last_served = 1.
  - All outputs reset to 0: grant, fifo_wr, fifo_wdata, drop_err, timeout_flag, arb_busy.
  - hold_cnt clears. Any in-flight write is lost.

## Timing
- req rising in ARB_IDLE at cycle N gives grant high at N+1; wr_ready is valid from N+1.
- A write accepted at cycle k gives fifo_wr high at k+1; throughput is 1 byte per cycle while the FIFO has space.
- Release at cycle k:
  - grant is low at k+1.
  - Without drain, the next grant comes at k+2 at the earliest.
  - With drain, the next grant comes 2 cycles after tx_empty is first seen with fifo_wr low.
- Watchdog: timeout_flag pulses at cycle G+hold_max-1 with no accepted writes, where G is the first grant cycle; grant is low one cycle later.
- drop_err and timeout_flag are registered one-cycle pulses, asserted the cycle after the event.

## Structure
- fec_pkg gains:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT, ARB_DRAIN};
  - constant ARB_HOLD_W = 16.
  - Reuse UART_MDW and UART_FAW.
- One sub-module, uart_tx_arb_pick: combinational winner selection from req, prio_mode and last_served, giving a one-hot result.
- The wr_ready, datapath register and watchdog stay in the top of the block.

## Test plan
- **Single requester:** req0 high, 5 writes 0x11–0x15 with last on 0x15 → grant = 01 one cycle after req, fifo_wr carries 0x11..0x15 each one cycle delayed, grant = 00 after the last.
- **Round-robin tie:** both req held, two messages each, prio_mode = 0 → grant order 01, 10, 01, 10 with one idle cycle between grants. With prio_mode = 1 → 01 repeatedly while req0 is held.
- **Backpressure:** tx_level = 15 with fifo_wr pending, then tx_full = 1 → wr_ready = 0, the write is dropped and drop_err pulses. Lower tx_full → the next write is accepted.
- **Non-owner write:** wr1 pulses while grant = 01 → drop_err = 10, no fifo_wr.
- **Watchdog:** hold_max = 8, req0 held with no writes → timeout_flag at grant+7, grant low at grant+8, then req1 is granted. hold_max = 0 → no timeout.
- **Drain and reset:**
  - drain_en = 1, tx_empty held low for 20 cycles after a message → no new grant until tx_empty rises.
  - rst_n low mid-message → all outputs 0 asynchronously; after reset, requester 0 wins a tie.
